// File: rtl/arb_types.sv
`default_nettype none
// ============================================================================
//  Module      : arb_types (package)
//  Description : Shared types and constants for the memory port arbiter.
//                arb_state_t : two-state transaction FSM encoding.
//                ARB_RR      : round-robin arbitration policy selector.
//                ARB_FIXED   : fixed-priority policy selector (port 0 wins).
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_types;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage : arb_types
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_picker
//  Description : Combinational request picker. In round-robin mode the
//                search begins at start_i and wraps; in fixed mode it begins
//                at index 0. The first requester found wins.
//  Ports       : req_i        - request vector, one bit per client
//                start_i      - first index searched in round-robin mode
//                fixed_i      - 1 = fixed priority, 0 = round-robin
//                valid_o      - at least one client is requesting
//                idx_o        - winning client index (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     start_i,
    input  logic                 fixed_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     idx_o
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    always_comb begin
        valid_o    = 1'b0;
        idx_o      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // Candidate order: identity for fixed, rotated by start_i otherwise.
            w_cand     = fixed_i ? k : ((int'(start_i) + k) % NUM_PORTS);
            w_cand_idx = IDX_W'(w_cand);
            if (!valid_o && req_i[w_cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = w_cand_idx;
            end
        end
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port among NUM_PORTS requesters. In IDLE
//                a winner is chosen (round-robin or fixed priority) and its
//                command is latched; in BUSY the memory side is driven only
//                from the latch until mem_resp, which is forwarded as a
//                one-cycle pulse to the granted client.
//  Ports       : clk, reset          - clock, async active-high reset
//                req_read/req_write  - per-client commands
//                req_wmask/address/wdata - per-client payload slices
//                req_resp/req_rdata  - completion pulse and broadcast data
//                mem_*               - shared memory port
//                gnt_idx             - current or last granted client
//                busy                - transaction outstanding
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import arb_types::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_PORTS-1:0]                  req_read,
    input  logic [NUM_PORTS-1:0]                  req_write,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   req_wmask,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       req_wdata,
    output logic [NUM_PORTS-1:0]                  req_resp,
    output logic [DATA_WIDTH-1:0]                 req_rdata,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [DATA_WIDTH/8-1:0]               mem_wmask,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic                                  mem_resp,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]          gnt_idx,
    output logic                                  busy
);

    localparam int C_IDX_W  = $clog2(NUM_PORTS);
    localparam int C_MASK_W = DATA_WIDTH / 8;

    arb_state_t            state_q,    state_d;
    logic                  read_q,     read_d;
    logic                  write_q,    write_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [C_MASK_W-1:0]   wmask_q,    wmask_d;
    logic [C_IDX_W-1:0]    gnt_q,      gnt_d;
    logic [C_IDX_W-1:0]    last_gnt_q, last_gnt_d;

    logic [NUM_PORTS-1:0]  w_req;
    logic [C_IDX_W-1:0]    w_start;
    logic                  w_fixed;
    logic                  w_valid;
    logic [C_IDX_W-1:0]    w_win;
    logic                  w_busy;

    assign w_req   = req_read | req_write;
    assign w_fixed = (PRIORITY_MODE == ARB_FIXED);
    // Round-robin search begins one past the last grant, wrapping at NUM_PORTS.
    assign w_start = (last_gnt_q == C_IDX_W'(NUM_PORTS - 1)) ? '0
                                                             : last_gnt_q + C_IDX_W'(1);

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (C_IDX_W)
    ) u_picker (
        .req_i   (w_req),
        .start_i (w_start),
        .fixed_i (w_fixed),
        .valid_o (w_valid),
        .idx_o   (w_win)
    );

    always_comb begin
        state_d    = state_q;
        read_d     = read_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_valid) begin
                    state_d    = ARB_BUSY;
                    gnt_d      = w_win;
                    last_gnt_d = w_win;
                    // A simultaneous read and write is recorded as a write.
                    write_d    = req_write[w_win];
                    read_d     = req_read[w_win] & ~req_write[w_win];
                    addr_d     = req_address[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
                    wmask_d    = req_wmask[w_win*C_MASK_W +: C_MASK_W];
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    state_d = ARB_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            gnt_q      <= '0;
            last_gnt_q <= C_IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign w_busy      = (state_q == ARB_BUSY);
    assign busy        = w_busy;
    assign gnt_idx     = gnt_q;
    // Command bits are cleared on completion, so they are low in IDLE.
    assign mem_read    = read_q;
    assign mem_write   = write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wmask   = wmask_q;
    assign req_rdata   = mem_rdata;

    always_comb begin
        req_resp = '0;
        if (w_busy && mem_resp) begin
            req_resp[gnt_q] = 1'b1;
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire
